lsu: RTL
========

LSU -- requirements
Module: lsu

Interface
REQ-001 SHALL have parameter RAM_LAT, default 1, meaning the number of extra RAM wait cycles (0..15).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on the rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have port req_en_i, input, 1 bit: memory request from ex.
REQ-005 SHALL have port req_rw_i, input, 1 bit: request direction, 1 = write, 0 = read.
REQ-006 SHALL have port req_addr_i, input, 32 bits: byte address.
REQ-007 SHALL have port req_data_i, input, 32 bits: write data.
REQ-008 SHALL have port busy_o, output, 1 bit: pipeline stall, active high.
REQ-009 SHALL have port done_o, output, 1 bit: one-cycle completion pulse.
REQ-010 SHALL have port rdata_o, output, 32 bits: last read data.
REQ-011 SHALL have port err_o, output, 1 bit: misaligned-access flag, valid with done_o.
REQ-012 SHALL have ports ram_en_o (out, 1), ram_rw_o (out, 1), ram_addr_o (out, 32), ram_data_o (out, 32) and ram_data_i (in, 32) to the data RAM.

Function
REQ-013 SHALL implement the FSM states IDLE, ACCESS, WAIT and DONE.
REQ-014 In IDLE with req_en_i=1, SHALL capture rw, addr and data, and go to ACCESS on the next edge.
REQ-015 In ACCESS, SHALL go to WAIT if RAM_LAT>0, else to DONE.
REQ-016 In WAIT, SHALL go to DONE when the wait counter reaches RAM_LAT-1.
REQ-017 In DONE, SHALL go to IDLE unconditionally; a request in DONE is not accepted that cycle.
REQ-018 SHALL assert ram_en_o only in ACCESS and WAIT.
REQ-019 SHALL drive ram_rw_o and ram_data_o from the captured values.
REQ-020 SHALL drive ram_addr_o as {captured addr[31:2], 2'b00}.
REQ-021 On a read, SHALL register ram_data_i into rdata_o on the last ram_en_o cycle; rdata_o is then visible in DONE.
REQ-022 rdata_o SHALL hold its value until the next read completes; writes leave it unchanged.
REQ-023 SHALL assert done_o only in DONE.
REQ-024 SHALL drive busy_o = (IDLE and req_en_i) or ACCESS or WAIT, combinationally; busy_o=0 in DONE.
REQ-025 Latency SHALL be: request seen in IDLE at cycle 0, done_o at cycle 2+RAM_LAT.
REQ-026 req_* changes while busy_o=1 SHALL be ignored.
REQ-027 The wait counter SHALL be 4 bits, cleared on entry to ACCESS, and SHALL never wrap.

Reset
REQ-028 rst=0 SHALL immediately force IDLE, counter=0, rdata_o=0, done_o=0, err_o=0, ram_en_o=0 and busy_o=req_en_i-independent 0, including mid-operation.
REQ-029 After reset release, the first edge with req_en_i=1 SHALL be accepted normally.

Configuration
REQ-030 With LSU_ALIGN_CHECK_EN defined: a request with addr[1:0]!=0 SHALL go IDLE->DONE without asserting ram_en_o, with err_o=1 and done_o=1 for one cycle, and rdata_o unchanged.
REQ-031 Without LSU_ALIGN_CHECK_EN: addr[1:0] SHALL be ignored and err_o SHALL be tied to 0.

Structure
REQ-032 The state enum (IDLE/ACCESS/WAIT/DONE) and the RW_WRITE/RW_READ constants SHALL live in shared package luu_pkg.
REQ-033 The wait counter SHALL be sub-module lsu_wait_cnt (inputs clr, en; output hit when count = RAM_LAT-1).

Verification
REQ-034 RAM_LAT=1, read addr 0x10 with RAM returning 0xDEADBEEF -> done_o at cycle 3, rdata_o=0xDEADBEEF, busy_o high cycles 0-2.
REQ-035 RAM_LAT=0, write addr 0x20 data 0x12345678 -> ram_en_o=1, ram_rw_o=1 for exactly 1 cycle, done_o at cycle 2, rdata_o unchanged.
REQ-036 Back-to-back reads with req_en_i held high -> second request accepted in the IDLE cycle after DONE, never in DONE.
REQ-037 LSU_ALIGN_CHECK_EN set, read addr 0x13 -> no ram_en_o, done_o=1 and err_o=1 at cycle 1; macro unset -> RAM accessed at 0x10.
REQ-038 RAM_LAT=3 read, rst=0 in WAIT -> ram_en_o=0 and busy_o=0 immediately, state IDLE, rdata_o=0.

Source files
------------

// File: rtl/luu_pkg.sv
// rtl/luu_pkg.sv - shared LSU state encoding, access-direction constants and address helper
package luu_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    DONE   = 2'd3
  } lsu_state_t;

  localparam logic RW_WRITE = 1'b1;
  localparam logic RW_READ  = 1'b0;

  function automatic logic [31:0] word_addr(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/lsu_wait_cnt.sv
// rtl/lsu_wait_cnt.sv - 4-bit saturating RAM wait counter, hit when count equals RAM_LAT-1
module lsu_wait_cnt #(
  parameter int unsigned RAM_LAT = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic hit
);

  localparam logic [3:0] HIT_VAL = (RAM_LAT == 0) ? 4'd0 : 4'(RAM_LAT - 1);

  logic [3:0] count;

  // Saturates at 15 so a stuck WAIT can never alias back onto HIT_VAL.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= 4'd0;
    end else if (clr) begin
      count <= 4'd0;
    end else if (en && (count != 4'hF)) begin
      count <= count + 4'd1;
    end
  end

  assign hit = (count == HIT_VAL);

endmodule

// File: rtl/lsu.sv
// rtl/lsu.sv - single-outstanding load/store unit to the data RAM, RAM_LAT extra wait cycles
// LSU_ALIGN_CHECK_EN: misaligned requests skip the RAM and complete with err_o set.
import luu_pkg::*;

module lsu #(
  parameter int unsigned RAM_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_en_i,
  input  logic        req_rw_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_data_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] rdata_o,
  output logic        err_o,
  output logic        ram_en_o,
  output logic        ram_rw_o,
  output logic [31:0] ram_addr_o,
  output logic [31:0] ram_data_o,
  input  logic [31:0] ram_data_i
);

  lsu_state_t  state, state_nxt;
  logic        cap_rw;
  logic [31:0] cap_addr;
  logic [31:0] cap_data;
  logic [31:0] rdata_q;
  logic        accept;
  logic        misalign;
  logic        hit;
  logic        rd_last;

  assign accept = (state == IDLE) && req_en_i;

`ifdef LSU_ALIGN_CHECK_EN
  logic err_q;

  assign misalign = |req_addr_i[1:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_q <= 1'b0;
    end else if (accept) begin
      err_q <= misalign;
    end
  end

  assign err_o = done_o && err_q;
`else
  assign misalign = 1'b0;
  assign err_o    = 1'b0;
`endif

  lsu_wait_cnt #(.RAM_LAT(RAM_LAT)) u_wait_cnt (
    .clk (clk),
    .rst (rst),
    .clr (accept && !misalign),
    .en  (state == WAIT),
    .hit (hit)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (req_en_i) state_nxt = misalign ? DONE : ACCESS;
      ACCESS:  state_nxt = (RAM_LAT != 0) ? WAIT : DONE;
      WAIT:    if (hit) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // busy_o is gated by rst so a held req_en_i cannot raise a stall during reset.
  always_comb begin
    ram_en_o = (state == ACCESS) || (state == WAIT);
    done_o   = (state == DONE);
    busy_o   = rst && (accept || ram_en_o);
    rd_last  = 1'b0;
    if (ram_en_o && (cap_rw == RW_READ)) begin
      rd_last = (state == ACCESS) ? (RAM_LAT == 0) : hit;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cap_rw   <= RW_READ;
      cap_addr <= 32'd0;
      cap_data <= 32'd0;
    end else if (accept) begin
      cap_rw   <= req_rw_i;
      cap_addr <= req_addr_i;
      cap_data <= req_data_i;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata_q <= 32'd0;
    end else if (rd_last) begin
      rdata_q <= ram_data_i;
    end
  end

  assign rdata_o    = rdata_q;
  assign ram_rw_o   = cap_rw;
  assign ram_addr_o = word_addr(cap_addr);
  assign ram_data_o = cap_data;

endmodule
